// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one data-memory port between queued stores and loads,
//            with starvation protection and store-to-load hazard blocking.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int ROB_W        = 6,
    parameter int SQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              store_valid,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [ROB_W-1:0]  store_rob,
    output logic              store_full,
    output logic              store_overflow,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ROB_W-1:0]  load_rob,
    output logic              load_accept,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              load_done,
    output logic [DATA_W-1:0] load_data,
    output logic [ROB_W-1:0]  load_rob_out,
    output logic              store_done,
    output logic [ROB_W-1:0]  store_rob_out
);

    localparam int c_ptr_w = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_stv_w = $clog2(STARVE_LIMIT + 1);

    localparam logic [c_cnt_w-1:0] c_depth        = c_cnt_w'(SQ_DEPTH);
    localparam logic [c_stv_w-1:0] c_starve_limit = c_stv_w'(STARVE_LIMIT);

    localparam logic [1:0] c_s_idle   = 2'd0;
    localparam logic [1:0] c_s_l_wait = 2'd1;
    localparam logic [1:0] c_s_s_wait = 2'd2;

    logic [ADDR_W-1:0]  r_sq_addr [SQ_DEPTH];
    logic [DATA_W-1:0]  r_sq_data [SQ_DEPTH];
    logic [ROB_W-1:0]   r_sq_rob  [SQ_DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic [c_stv_w-1:0] r_starve;
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               r_overflow;
    logic [ROB_W-1:0]   r_load_rob;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_load_done;
    logic [DATA_W-1:0]  r_load_data;
    logic [ROB_W-1:0]   r_load_rob_out;
    logic               r_store_done;
    logic [ROB_W-1:0]   r_store_rob_out;

    logic [SQ_DEPTH-1:0] w_hit;
    logic               w_blocked;
    logic               w_queue_empty;
    logic               w_starve_ok;
    logic               w_load_grant;
    logic               w_store_grant;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    // An entry is live when its distance from head is below the count.
    generate
        for (genvar i = 0; i < SQ_DEPTH; i++) begin : g_hazard
            logic [c_ptr_w-1:0] w_offset;
            assign w_offset = c_ptr_w'(i) - r_head;
            assign w_hit[i] = ({1'b0, w_offset} < r_count) &&
                              (r_sq_addr[i][ADDR_W-1:2] == load_addr[ADDR_W-1:2]);
        end
    endgenerate

    assign w_blocked     = |w_hit;
    assign w_queue_empty = (r_count == '0);
    assign w_starve_ok   = w_queue_empty || (r_starve < c_starve_limit);
    assign w_pop         = (r_state == c_s_s_wait) && mem_ready;
    assign w_push        = store_valid && ((r_count != c_depth) || w_pop);
    assign w_drop        = store_valid && !w_push;

    always_comb begin
        w_state_next  = r_state;
        w_load_grant  = 1'b0;
        w_store_grant = 1'b0;
        case (r_state)
            c_s_idle: begin
                if (load_valid && !w_blocked && w_starve_ok) begin
                    w_load_grant = 1'b1;
                    w_state_next = c_s_l_wait;
                end else if (!w_queue_empty) begin
                    w_store_grant = 1'b1;
                    w_state_next  = c_s_s_wait;
                end
            end
            c_s_l_wait, c_s_s_wait: begin
                if (mem_ready) begin
                    w_state_next = c_s_idle;
                end
            end
            default: w_state_next = c_s_idle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Queue payload needs no reset: only entries inside the count are read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_sq_addr[r_tail] <= store_addr;
            r_sq_data[r_tail] <= store_data;
            r_sq_rob[r_tail]  <= store_rob;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_starve        <= '0;
            r_overflow      <= 1'b0;
            r_load_rob      <= '0;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_load_done     <= 1'b0;
            r_load_data     <= '0;
            r_load_rob_out  <= '0;
            r_store_done    <= 1'b0;
            r_store_rob_out <= '0;
        end else begin
            r_load_done  <= 1'b0;
            r_store_done <= 1'b0;
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_load_grant) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= load_addr;
                r_load_rob <= load_rob;
                if (!w_queue_empty && (r_starve < c_starve_limit)) begin
                    r_starve <= r_starve + 1'b1;
                end
            end
            if (w_store_grant) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_sq_addr[r_head];
                r_mem_wdata <= r_sq_data[r_head];
                r_starve    <= '0;
            end
            if ((r_state == c_s_l_wait) && mem_ready) begin
                r_mem_req      <= 1'b0;
                r_load_done    <= 1'b1;
                r_load_data    <= mem_rdata;
                r_load_rob_out <= r_load_rob;
            end
            if (w_pop) begin
                r_mem_req       <= 1'b0;
                r_store_done    <= 1'b1;
                r_store_rob_out <= r_sq_rob[r_head];
            end
        end
    end

    assign load_accept    = w_load_grant && !reset;
    assign store_full     = (r_count == c_depth);
    assign store_overflow = r_overflow;
    assign mem_req        = r_mem_req;
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign load_done      = r_load_done;
    assign load_data      = r_load_data;
    assign load_rob_out   = r_load_rob_out;
    assign store_done     = r_store_done;
    assign store_rob_out  = r_store_rob_out;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed scenarios plus randomized traffic against a
//            transaction-level reference model of the memory port arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int ROB_W        = 6;
    localparam int SQ_DEPTH     = 4;
    localparam int STARVE_LIMIT = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              store_valid;
    logic [ADDR_W-1:0] store_addr;
    logic [DATA_W-1:0] store_data;
    logic [ROB_W-1:0]  store_rob;
    logic              store_full;
    logic              store_overflow;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [ROB_W-1:0]  load_rob;
    logic              load_accept;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              load_done;
    logic [DATA_W-1:0] load_data;
    logic [ROB_W-1:0]  load_rob_out;
    logic              store_done;
    logic [ROB_W-1:0]  store_rob_out;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROB_W(ROB_W),
        .SQ_DEPTH(SQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .store_valid(store_valid), .store_addr(store_addr), .store_data(store_data),
        .store_rob(store_rob), .store_full(store_full), .store_overflow(store_overflow),
        .load_valid(load_valid), .load_addr(load_addr), .load_rob(load_rob),
        .load_accept(load_accept), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .load_done(load_done), .load_data(load_data),
        .load_rob_out(load_rob_out), .store_done(store_done), .store_rob_out(store_rob_out)
    );

    // Reference model: the store queue is a plain SV queue, the port holds
    // at most one transaction kind (0 none, 1 load, 2 store).
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob;
    } st_t;

    st_t               m_sq[$];
    int                m_busy   = 0;
    int                m_starve = 0;
    bit                m_ovf    = 1'b0;
    logic [ROB_W-1:0]  m_lrob   = '0;
    logic              e_req = 1'b0, e_we = 1'b0, e_ldone = 1'b0, e_sdone = 1'b0;
    logic [ADDR_W-1:0] e_addr  = '0;
    logic [DATA_W-1:0] e_wdata = '0, e_ldata = '0;
    logic [ROB_W-1:0]  e_lrob  = '0, e_srob = '0;

    function automatic bit m_blocked();
        foreach (m_sq[i]) begin
            if (m_sq[i].addr[ADDR_W-1:2] == load_addr[ADDR_W-1:2]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_accept();
        return !reset && (m_busy == 0) && load_valid && !m_blocked() &&
               ((m_sq.size() == 0) || (m_starve < STARVE_LIMIT));
    endfunction

    task automatic model_update();
        int  n0;
        bit  pop;
        bit  acc;
        st_t e;
        if (reset) begin
            m_sq.delete();
            m_busy = 0; m_starve = 0; m_ovf = 1'b0; m_lrob = '0;
            e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
            e_ldone = 1'b0; e_sdone = 1'b0; e_ldata = '0; e_lrob = '0; e_srob = '0;
            return;
        end
        n0  = m_sq.size();
        acc = m_accept();
        pop = (m_busy == 2) && mem_ready;
        e_ldone = 1'b0;
        e_sdone = 1'b0;
        if ((m_busy == 1) && mem_ready) begin
            e_ldone = 1'b1; e_ldata = mem_rdata; e_lrob = m_lrob;
            e_req = 1'b0; m_busy = 0;
        end else if (pop) begin
            e = m_sq.pop_front();
            e_sdone = 1'b1; e_srob = e.rob;
            e_req = 1'b0; m_busy = 0;
        end else if (m_busy == 0) begin
            if (acc) begin
                e_req = 1'b1; e_we = 1'b0; e_addr = load_addr; m_lrob = load_rob;
                if ((n0 > 0) && (m_starve < STARVE_LIMIT)) m_starve++;
                m_busy = 1;
            end else if (n0 > 0) begin
                e_req = 1'b1; e_we = 1'b1; e_addr = m_sq[0].addr; e_wdata = m_sq[0].data;
                m_starve = 0;
                m_busy = 2;
            end
        end
        if (store_valid) begin
            if ((n0 < SQ_DEPTH) || pop) begin
                e.addr = store_addr; e.data = store_data; e.rob = store_rob;
                m_sq.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        reset = 1'b0; store_valid = 1'b0; store_addr = '0; store_data = '0; store_rob = '0;
        load_valid = 1'b0; load_addr = '0; load_rob = '0; mem_ready = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        load_valid = 1'b1; load_addr = 32'h40;
        #1;
        checks++; if (load_accept !== 1'b0) begin errors++; $display("FAIL reset_accept: got %b want 0", load_accept); end
        load_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (store_full !== 1'b0 || store_overflow !== 1'b0) begin
            errors++; $display("FAIL reset_queue_flags: got full=%b ovf=%b want 0 0", store_full, store_overflow); end
        checks++; if (load_done !== 1'b0 || store_done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b %b want 0 0", load_done, store_done); end
        checks++; if (mem_addr !== '0 || load_data !== '0 || load_rob_out !== '0 || store_rob_out !== '0) begin
            errors++; $display("FAIL reset_outputs: got addr=%0h ld=%0h lrob=%0h srob=%0h want 0", mem_addr, load_data, load_rob_out, store_rob_out); end
    endtask

    task automatic test_load_latency();
        clear_inputs();
        do_reset();
        load_valid = 1'b1; load_addr = 32'h100; load_rob = 6'd5;
        #1;
        checks++; if (load_accept !== 1'b1) begin errors++; $display("FAIL lat_accept: got %b want 1", load_accept); end
        cyc();
        load_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            errors++; $display("FAIL lat_req: got req=%b we=%b addr=%0h want 1 0 100", mem_req, mem_we, mem_addr); end
        cyc();
        mem_ready = 1'b0;
        #1;
        checks++; if (load_done !== 1'b1 || load_data !== 32'hDEADBEEF || load_rob_out !== 6'd5) begin
            errors++; $display("FAIL lat_done: got done=%b data=%0h rob=%0d want 1 deadbeef 5", load_done, load_data, load_rob_out); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lat_req_drop: got %b want 0", mem_req); end
        cyc();
        checks++; if (load_done !== 1'b0 || load_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lat_pulse_hold: got done=%b data=%0h want 0 deadbeef", load_done, load_data); end
    endtask

    task automatic test_store_overflow();
        int tags[$];
        clear_inputs();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            store_valid = 1'b1; store_addr = 32'h2000 + 32'(k * 16);
            store_data = 32'hA000 + 32'(k); store_rob = 6'(k);
            #1;
            if (k == 4) begin
                checks++; if (store_full !== 1'b0) begin errors++; $display("FAIL ovf_full_early: got %b want 0", store_full); end
            end
            if (k == 5) begin
                checks++; if (store_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", store_full); end
            end
            cyc();
        end
        store_valid = 1'b0;
        #1;
        checks++; if (store_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky_set: got %b want 1", store_overflow); end
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2010 || mem_wdata !== 32'hA001) begin
            errors++; $display("FAIL ovf_head_write: got req=%b we=%b addr=%0h wd=%0h want 1 1 2010 a001", mem_req, mem_we, mem_addr, mem_wdata); end
        mem_ready = 1'b1;
        for (int c = 0; c < 40 && tags.size() < 4; c++) begin
            cyc();
            if (store_done) tags.push_back(int'(store_rob_out));
        end
        mem_ready = 1'b0;
        checks++; if (tags.size() != 4) begin errors++; $display("FAIL ovf_done_count: got %0d want 4", tags.size()); end
        foreach (tags[i]) begin
            checks++; if (tags[i] != i + 1) begin errors++; $display("FAIL ovf_tag_order[%0d]: got %0d want %0d", i, tags[i], i + 1); end
        end
        cyc();
        checks++; if (store_overflow !== 1'b1 || store_full !== 1'b0) begin
            errors++; $display("FAIL ovf_after_drain: got ovf=%b full=%b want 1 0", store_overflow, store_full); end
    endtask

    task automatic test_hazard();
        int early = 0;
        clear_inputs();
        do_reset();
        store_valid = 1'b1; store_addr = 32'h200; store_data = 32'h55; store_rob = 6'd7;
        cyc();
        store_valid = 1'b0;
        load_valid = 1'b1; load_addr = 32'h202; load_rob = 6'd9;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (load_accept) early++;
            cyc();
        end
        checks++; if (early != 0) begin errors++; $display("FAIL haz_blocked: got %0d accepts want 0", early); end
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200) begin
            errors++; $display("FAIL haz_store_first: got req=%b we=%b addr=%0h want 1 1 200", mem_req, mem_we, mem_addr); end
        mem_ready = 1'b1;
        #1;
        checks++; if (load_accept !== 1'b0) begin errors++; $display("FAIL haz_accept_in_wait: got %b want 0", load_accept); end
        cyc();
        mem_ready = 1'b0;
        #1;
        checks++; if (store_done !== 1'b1 || store_rob_out !== 6'd7) begin
            errors++; $display("FAIL haz_store_done: got %b rob=%0d want 1 7", store_done, store_rob_out); end
        checks++; if (load_accept !== 1'b1) begin errors++; $display("FAIL haz_release: got %b want 1", load_accept); end
        cyc();
        load_valid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h202) begin
            errors++; $display("FAIL haz_load_req: got req=%b we=%b addr=%0h want 1 0 202", mem_req, mem_we, mem_addr); end
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        cyc();
    endtask

    task automatic test_starvation();
        bit kinds[$];
        bit expk[11];
        bit acc;
        expk = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        clear_inputs();
        do_reset();
        load_valid = 1'b1; load_addr = 32'h4000; load_rob = 6'd1;
        store_valid = 1'b1; store_addr = 32'h3000; store_data = 32'h1; store_rob = 6'd20;
        #1;
        checks++; if (load_accept !== 1'b1) begin errors++; $display("FAIL stv_first_accept: got %b want 1", load_accept); end
        cyc();
        load_addr = 32'h4004; load_rob = 6'd2;
        store_addr = 32'h3010; store_data = 32'h2; store_rob = 6'd21;
        cyc();
        store_valid = 1'b0;
        mem_ready = 1'b1;
        for (int c = 0; c < 80 && kinds.size() < 11; c++) begin
            #1;
            acc = load_accept;
            if (mem_req) kinds.push_back(mem_we);
            cyc();
            if (acc) begin
                load_addr = load_addr + 32'd4;
                load_rob = load_rob + 6'd1;
            end
        end
        load_valid = 1'b0;
        checks++; if (kinds.size() != 11) begin errors++; $display("FAIL stv_grant_count: got %0d want 11", kinds.size()); end
        foreach (kinds[i]) begin
            checks++; if (kinds[i] != expk[i]) begin errors++; $display("FAIL stv_grant_kind[%0d]: got we=%0d want we=%0d", i, kinds[i], expk[i]); end
        end
        for (int c = 0; c < 4; c++) cyc();
        mem_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        int tags[$];
        int expt[4];
        expt = '{11, 12, 13, 30};
        clear_inputs();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            store_valid = 1'b1; store_addr = 32'h5000 + 32'(k * 16);
            store_data = 32'hB000 + 32'(k); store_rob = 6'(10 + k);
            cyc();
        end
        store_valid = 1'b0;
        #1;
        checks++; if (store_full !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h5000) begin
            errors++; $display("FAIL fpp_setup: got full=%b req=%b we=%b addr=%0h want 1 1 1 5000", store_full, mem_req, mem_we, mem_addr); end
        store_valid = 1'b1; store_addr = 32'h5100; store_data = 32'hC0; store_rob = 6'd30;
        mem_ready = 1'b1;
        cyc();
        store_valid = 1'b0; mem_ready = 1'b0;
        #1;
        checks++; if (store_overflow !== 1'b0 || store_full !== 1'b1) begin
            errors++; $display("FAIL fpp_count: got ovf=%b full=%b want 0 1", store_overflow, store_full); end
        checks++; if (store_done !== 1'b1 || store_rob_out !== 6'd10) begin
            errors++; $display("FAIL fpp_done: got %b rob=%0d want 1 10", store_done, store_rob_out); end
        mem_ready = 1'b1;
        for (int c = 0; c < 40 && tags.size() < 4; c++) begin
            cyc();
            if (store_done) tags.push_back(int'(store_rob_out));
        end
        mem_ready = 1'b0;
        checks++; if (tags.size() != 4) begin errors++; $display("FAIL fpp_drain_count: got %0d want 4", tags.size()); end
        foreach (tags[i]) begin
            checks++; if (i < 4 && tags[i] != expt[i]) begin errors++; $display("FAIL fpp_tag[%0d]: got %0d want %0d", i, tags[i], expt[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        int spurious = 0;
        clear_inputs();
        do_reset();
        load_valid = 1'b1; load_addr = 32'h6000; load_rob = 6'd3;
        store_valid = 1'b1; store_addr = 32'h7000; store_data = 32'h70; store_rob = 6'd40;
        #1;
        checks++; if (load_accept !== 1'b1) begin errors++; $display("FAIL rmf_accept: got %b want 1", load_accept); end
        cyc();
        load_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            store_addr = 32'h7000 + 32'(k * 16); store_rob = 6'(40 + k);
            cyc();
        end
        store_valid = 1'b0;
        #1;
        checks++; if (store_full !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rmf_setup: got full=%b req=%b we=%b want 1 1 0", store_full, mem_req, mem_we); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || load_done !== 1'b0 || store_full !== 1'b0) begin
            errors++; $display("FAIL rmf_abandon: got req=%b done=%b full=%b want 0 0 0", mem_req, load_done, store_full); end
        mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (load_done || store_done || mem_req) spurious++;
        end
        mem_ready = 1'b0;
        checks++; if (spurious != 0) begin errors++; $display("FAIL rmf_quiet: got %0d active cycles want 0", spurious); end
    endtask

    task automatic test_random();
        bit acc;
        clear_inputs();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 299) == 0);
            store_valid = ($urandom_range(0, 2) == 0);
            store_addr  = 32'h1000 + 32'($urandom_range(0, 31));
            store_data  = $urandom;
            store_rob   = 6'($urandom);
            if (!load_valid && ($urandom_range(0, 1) == 1)) begin
                load_valid = 1'b1;
                load_addr  = 32'h1000 + 32'($urandom_range(0, 47));
                load_rob   = 6'($urandom);
            end
            mem_ready = ($urandom_range(0, 1) == 1);
            mem_rdata = $urandom;
            #1;
            acc = m_accept();
            checks++; if (load_accept !== acc) begin errors++; $display("FAIL rnd_accept c%0d: got %b want %b", c, load_accept, acc); end
            checks++; if (store_full !== (m_sq.size() == SQ_DEPTH)) begin errors++; $display("FAIL rnd_full c%0d: got %b want %0d", c, store_full, m_sq.size() == SQ_DEPTH); end
            checks++; if (store_overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, store_overflow, m_ovf); end
            checks++; if (mem_req !== e_req) begin errors++; $display("FAIL rnd_req c%0d: got %b want %b", c, mem_req, e_req); end
            if (e_req) begin
                checks++; if (mem_we !== e_we || mem_addr !== e_addr) begin
                    errors++; $display("FAIL rnd_cmd c%0d: got we=%b addr=%0h want %b %0h", c, mem_we, mem_addr, e_we, e_addr); end
                if (e_we) begin
                    checks++; if (mem_wdata !== e_wdata) begin errors++; $display("FAIL rnd_wdata c%0d: got %0h want %0h", c, mem_wdata, e_wdata); end
                end
            end
            checks++; if (load_done !== e_ldone || store_done !== e_sdone) begin
                errors++; $display("FAIL rnd_done c%0d: got ld=%b st=%b want %b %b", c, load_done, store_done, e_ldone, e_sdone); end
            if (e_ldone) begin
                checks++; if (load_data !== e_ldata || load_rob_out !== e_lrob) begin
                    errors++; $display("FAIL rnd_load c%0d: got %0h/%0d want %0h/%0d", c, load_data, load_rob_out, e_ldata, e_lrob); end
            end
            if (e_sdone) begin
                checks++; if (store_rob_out !== e_srob) begin errors++; $display("FAIL rnd_store_rob c%0d: got %0d want %0d", c, store_rob_out, e_srob); end
            end
            cyc();
            if (acc) load_valid = 1'b0;
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_load_latency();
        test_store_overflow();
        test_hazard();
        test_starvation();
        test_full_push_pop();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between the store reservation station and the load unit.
- The store RS issues one-cycle store pulses with no backpressure, so this block absorbs them in a small in-order store queue.
- Grants the port to loads or queued stores by priority with starvation protection and store-to-load address hazard checking.
- Returns completion pulses tagged with the ROB number for CDB/ROB commit.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ROB_W, 6, ROB tag width
- SQ_DEPTH, 4, store queue entries (power of two)
- STARVE_LIMIT, 4, consecutive load grants allowed while stores wait

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- store_valid  in  1  one-cycle store issue pulse from store RS
- store_addr  in  ADDR_W  effective store address (base+offset already added)
- store_data  in  DATA_W  store value
- store_rob  in  ROB_W  ROB tag of store
- store_full  out  1  combinational; queue count == SQ_DEPTH
- store_overflow  out  1  sticky error; a push was dropped
- load_valid  in  1  load request, held until load_accept
- load_addr  in  ADDR_W  load address
- load_rob  in  ROB_W  ROB tag of load
- load_accept  out  1  one-cycle pulse; load request taken
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  memory completes the current request this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- load_done  out  1  one-cycle completion pulse
- load_data  out  DATA_W  loaded value
- load_rob_out  out  ROB_W  tag of completed load
- store_done  out  1  one-cycle completion pulse
- store_rob_out  out  ROB_W  tag of completed store

Behaviour:
- Reset (synchronous) clears:
  - the queue (head, tail, count to 0) and the starvation counter;
  - store_overflow;
  - state to IDLE;
  - all outputs to 0.
- Reset mid-transaction abandons the transaction: mem_req is 0 the next cycle and no done pulse is issued.
- Store queue:
  - Circular FIFO; pointers wrap modulo SQ_DEPTH.
  - Push on store_valid when count < SQ_DEPTH, or when count == SQ_DEPTH and a pop occurs in the same cycle.
  - Otherwise the push is dropped and store_overflow is set until reset.
  - Pop occurs at store completion (mem_ready in S_WAIT).
  - Simultaneous push and pop leaves count unchanged.
- Hazard: load_valid with load_addr[ADDR_W-1:2] equal to any valid queue entry's address[ADDR_W-1:2] marks the load blocked. A blocked load is never granted.
- FSM states: IDLE, L_WAIT, S_WAIT.
- IDLE grant choice, evaluated each cycle:
  - (a) load_valid, not blocked, and (queue empty or starve_cnt < STARVE_LIMIT): grant load.
    - Pulse load_accept this cycle and latch load_addr and load_rob.
    - Next cycle: mem_req=1, mem_we=0; go to L_WAIT.
    - Increment starve_cnt (saturating) if the queue is non-empty.
  - (b) else if the queue is non-empty: grant the head entry.
    - Next cycle: mem_req=1, mem_we=1, mem_addr/mem_wdata from head; go to S_WAIT.
    - starve_cnt := 0.
  - (c) else stay IDLE with mem_req=0.
- L_WAIT / S_WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until a cycle with mem_ready=1.
  - On that cycle, register the completion: next cycle load_done=1 with load_data=mem_rdata and latched tag, or store_done=1 with the head tag.
  - Go to IDLE in the same edge; mem_req=0 next cycle.
- Minimum spacing: one IDLE cycle between transactions.
- Latency: a load arriving into IDLE with zero-wait memory completes as follows:
  - accept at cycle 0;
  - mem_req at cycle 1 with mem_ready=1;
  - load_done at cycle 2.
- Done pulses last exactly one cycle; data/tag outputs hold their value until the next done.
- mem_ready outside L_WAIT/S_WAIT is ignored.

Test Plan:
1. Reset, then load_valid addr=0x100 rob=5, memory returns 0xDEADBEEF with zero wait -> load_accept cycle 0; mem_req=1, mem_we=0, mem_addr=0x100 cycle 1; load_done=1, load_data=0xDEADBEEF, load_rob_out=5 cycle 2.
2. Five store pulses (rob 1..5) on consecutive cycles with memory stalled -> store_full=1 after the 4th; the 5th is dropped; store_overflow=1; store_done tags 1,2,3,4 in order.
3. Store addr=0x200 queued, then load addr=0x202 -> load_accept withheld until store_done of that store; load then granted.
4. Queue holding 2 stores, load_valid continuously asserted with distinct addresses, STARVE_LIMIT=4 -> 4 load grants, then 1 store grant, starve_cnt back to 0.
5. Full queue in S_WAIT with store_valid coinciding with the mem_ready cycle -> push accepted, count stays 4, no overflow.
6. Reset asserted in L_WAIT before mem_ready -> next cycle mem_req=0, no load_done, queue empty, store_full=0.
